// File: rtl/wbpipe_ram_if.sv
// Pipelined Wishbone request/response bundle for wbpipe_ram.
// Signal names are given from the slave's point of view.
interface wbpipe_ram_if #(
  parameter int AW = 32
);
  logic          i_wb_cyc;
  logic          i_wb_stb;
  logic          i_wb_we;
  logic [AW-1:0] i_wb_addr;
  logic [31:0]   i_wb_data;
  logic          o_wb_ack;
  logic          o_wb_stall;
  logic          o_wb_err;
  logic [31:0]   o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
  );
endinterface

// File: rtl/wbpipe_ram.sv
// Two-stage pipelined Wishbone RAM that zero-fills itself after reset.
// state | meaning: CLEAR | zero-filling memory, bus stalled; READY | serving requests
module wbpipe_ram #(
  parameter int            LGMEMSZ = 10,
  parameter int            AW      = 32,
  parameter logic [AW-1:0] BASE    = AW'(32'h0000_2000)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wbpipe_ram_if.slave   wb
);
  localparam int MEMSZ = 1 << LGMEMSZ;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state_q;
  logic [LGMEMSZ-1:0]   clr_cnt_q, clr_cnt_d;
  logic                 stall_q;
  logic                 ack_q, err_q;
  logic [31:0]          data_q;
  logic [31:0]          mem_q [MEMSZ];

  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_we_q, s1_we_d;
  logic                 s1_ok_q, s1_ok_d;
  logic [LGMEMSZ-1:0]   s1_addr_q, s1_addr_d;
  logic [31:0]          s1_data_q, s1_data_d;

  always_comb begin
    clr_cnt_d = clr_cnt_q + LGMEMSZ'(1);
    s1_vld_d  = wb.i_wb_cyc & wb.i_wb_stb & ~stall_q;
    s1_we_d   = wb.i_wb_we;
    s1_ok_d   = (wb.i_wb_addr[AW-1:LGMEMSZ] == BASE[AW-1:LGMEMSZ]);
    s1_addr_d = wb.i_wb_addr[LGMEMSZ-1:0];
    s1_data_d = wb.i_wb_data;
  end

  // Control, stage valid and registered bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      stall_q   <= 1'b1;
      s1_vld_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (&clr_cnt_q) begin
            state_q <= READY;
            stall_q <= 1'b0;
          end
        end
        default: stall_q <= 1'b0;
      endcase
      s1_vld_q <= s1_vld_d;
      // A dropped cycle suppresses the response but not a stage-1 write.
      ack_q    <= s1_vld_q & wb.i_wb_cyc & s1_ok_q;
      err_q    <= s1_vld_q & wb.i_wb_cyc & ~s1_ok_q;
      if (s1_vld_q && s1_ok_q && !s1_we_q)
        data_q <= mem_q[s1_addr_q];
    end
  end

  always_ff @(posedge i_clk) begin
    s1_we_q   <= s1_we_d;
    s1_ok_q   <= s1_ok_d;
    s1_addr_q <= s1_addr_d;
    s1_data_q <= s1_data_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == CLEAR)
        mem_q[clr_cnt_q] <= '0;
      else if (s1_vld_q && s1_ok_q && s1_we_q)
        mem_q[s1_addr_q] <= s1_data_q;
    end
  end

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_err   = err_q;
  assign wb.o_wb_stall = stall_q;
  assign wb.o_wb_data  = data_q;
endmodule

// File: doc/wbpipe_ram.md
WBPIPE_RAM -- requirements
Module: wbpipe_ram

Interface
REQ-001 SHALL have parameter LGMEMSZ, default 10; memory holds 2^LGMEMSZ 32-bit words.
REQ-002 SHALL have parameter AW, default 32; word-address width of i_wb_addr.
REQ-003 SHALL have parameter BASE, default 32'h00002000; word address of memory word 0, aligned to 2^LGMEMSZ.
REQ-004 SHALL have one clock, i_clk; reset is synchronous and active-high, i_rst.
REQ-005 i_clk  input  1  clock; every register updates on its rising edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_wb_cyc  input  1  bus cycle active.
REQ-008 i_wb_stb  input  1  request strobe.
REQ-009 i_wb_we  input  1  1=write, 0=read.
REQ-010 i_wb_addr  input  AW  word address.
REQ-011 i_wb_data  input  32  write data.
REQ-012 o_wb_ack  output  1  request completed.
REQ-013 o_wb_stall  output  1  request not accepted this cycle.
REQ-014 o_wb_err  output  1  request completed with a bus error.
REQ-015 o_wb_data  output  32  read data, valid when o_wb_ack=1.

Function
REQ-016 SHALL accept a request on any cycle with i_wb_cyc=1, i_wb_stb=1 and o_wb_stall=0, at up to one request per clock.
REQ-017 SHALL treat an address as in range when i_wb_addr[AW-1:LGMEMSZ] equals BASE[AW-1:LGMEMSZ].
REQ-018 SHALL index memory with i_wb_addr[LGMEMSZ-1:0].
REQ-019 SHALL have two states: CLEAR and READY.
REQ-020 CLEAR: a counter SHALL write 32'h0 to words 0..2^LGMEMSZ-1, one word per clock, in ascending order, with o_wb_stall=1.
REQ-021 SHALL move from CLEAR to READY on the cycle after word 2^LGMEMSZ-1 is written; the counter SHALL wrap to 0.
REQ-022 READY: o_wb_stall SHALL be 0.
REQ-023 Stage 1 (cycle after acceptance), in-range write: SHALL write i_wb_data to memory.
REQ-024 Stage 1, in-range read: SHALL register the addressed word.
REQ-025 Stage 1, out-of-range request: SHALL leave memory unmodified and flag the stage as an error.
REQ-026 Stage 2: for an in-range request, o_wb_ack SHALL assert for exactly one cycle, two cycles after acceptance.
REQ-027 Stage 2: for an out-of-range request, o_wb_err SHALL assert instead of o_wb_ack.
REQ-028 o_wb_ack and o_wb_err SHALL never assert in the same cycle.
REQ-029 Write requests SHALL be acknowledged with the same latency as reads; o_wb_data is don't-care on write acks.
REQ-030 Responses SHALL return in acceptance order, with no gaps added for back-to-back requests.
REQ-031 A read accepted one cycle after a write to the same address SHALL return the newly written data.
REQ-032 When i_wb_cyc=0, both pipeline stages SHALL be cleared.
REQ-033 Neither o_wb_ack nor o_wb_err SHALL assert in the cycle after any cycle with i_wb_cyc=0.
REQ-034 A write flushed by i_wb_cyc=0 before stage 1 SHALL NOT modify memory; one already at stage 1 SHALL complete its write.
REQ-035 An error response SHALL NOT cancel later in-flight requests; they complete normally while i_wb_cyc=1.
REQ-036 i_wb_stb with i_wb_cyc=0 SHALL be ignored.

Reset
REQ-037 On i_rst=1, the block SHALL enter CLEAR with the clear counter at 0.
REQ-038 On i_rst=1, both pipeline stage valid flags SHALL be cleared.
REQ-039 Reset output values SHALL be: o_wb_ack=0, o_wb_err=0, o_wb_stall=1, o_wb_data=0.
REQ-040 Power-up (initial) state SHALL equal the post-reset state.
REQ-041 A reset asserted mid-operation SHALL discard all in-flight requests and restart the full CLEAR sequence.
REQ-042 A reset asserted during CLEAR SHALL restart the clear counter at 0.

Verification
REQ-043 Clear: LGMEMSZ=4, BASE=32'h2000; release reset -> o_wb_stall=1 for 16 cycles, then 0; read 32'h200F -> ack with data 32'h0.
REQ-044 Pipelined throughput: write 32'hDEADBEEF to 32'h2003, then read 32'h2003 on the next clock (cyc held) -> two consecutive acks at acceptance+2; second o_wb_data=32'hDEADBEEF.
REQ-045 Burst: 8 back-to-back reads of 32'h2000..32'h2007 after writing value=address to each -> 8 consecutive ack cycles with data 32'h2000..32'h2007 in order.
REQ-046 Error: read 32'h3000, then read 32'h2001 the next clock -> o_wb_err at acceptance+2, o_wb_ack one cycle later, never both in one cycle.
REQ-047 Abort: accept write 32'h5 to 32'h2004, drop i_wb_cyc the next cycle -> no ack or err; a later read of 32'h2004 returns 32'h5.
REQ-048 Reset mid-burst: assert i_rst one cycle with 2 reads in flight -> no acks, o_wb_stall=1 for 16 cycles, all memory reads 32'h0.
